mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1; legal when 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter MODE, default MODE_WRAP; MODE_WRAP wraps at the range ends, MODE_SAT holds at them.
REQ-004 SHALL have parameter PRESCALE, default 1, clock cycles per count step; used only when COUNTER_PRESCALE_EN is defined.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port clear  input  1  synchronous clear of count and flags.
REQ-008 SHALL have port load  input  1  synchronous load of load_val.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port en  input  1  count enable.
REQ-011 SHALL have port up_dn  input  1  direction, 1 = up, 0 = down.
REQ-012 SHALL have port count  output  WIDTH  registered count value.
REQ-013 SHALL have port tc  output  1  terminal count (combinational).
REQ-014 SHALL have port wrap  output  1  registered one-cycle pulse, boundary event.
REQ-015 SHALL have port load_err  output  1  sticky flag, out-of-range load seen.

Function
REQ-016 SHALL apply, per rising edge, priority clear > load > step; step = en AND tick.
REQ-017 SHALL, on clear, set count=0, wrap=0, load_err=0.
REQ-018 SHALL, on load with load_val < MODULUS, set count=load_val next cycle; otherwise set count=MODULUS-1 and load_err=1.
REQ-019 SHALL, on step, increment count when up_dn=1 and decrement it when up_dn=0, with one-cycle latency.
REQ-020 SHALL, in MODE_WRAP, step MODULUS-1 up to 0 and 0 down to MODULUS-1, and pulse wrap in the cycle after.
REQ-021 SHALL, in MODE_SAT, hold count at MODULUS-1 (up) or 0 (down) when stepping at that end, and still pulse wrap.
REQ-022 SHALL drive tc=1 when (up_dn=1 and count==MODULUS-1) or (up_dn=0 and count==0).
REQ-023 SHALL drive wrap=0 in every cycle without a boundary step, including cycles with load or clear.
REQ-024 SHALL hold count when en=0; a direction change takes effect on the next step.
REQ-025 SHALL never let count exceed MODULUS-1.

Reset
REQ-026 SHALL, on reset asserted, immediately set count=0, wrap=0, load_err=0, and reset the prescaler phase to 0.
REQ-027 SHALL take no step on the first edge after reset deasserts unless en=1 and tick=1.
REQ-028 SHALL, on reset asserted mid-count or mid-prescale, abandon the step in progress without a wrap pulse.

Configuration
REQ-029 SHALL, with COUNTER_PRESCALE_EN defined, raise tick one cycle in every PRESCALE cycles.
REQ-030 SHALL count prescaler cycles only while en=1; clear and load reset the prescaler phase.
REQ-031 SHALL, without COUNTER_PRESCALE_EN, tie tick to 1, omit the prescaler logic, and ignore PRESCALE.

Structure
REQ-032 SHALL place constants MODE_WRAP=0 and MODE_SAT=1 in shared package counter_pkg.
REQ-033 SHALL place the prescaler in sub-module counter_prescaler (ports clk, reset, en, restart, tick), instantiated only under COUNTER_PRESCALE_EN.
REQ-034 SHALL check parameter legality at elaboration and fail on illegal MODULUS or PRESCALE < 1.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-035 SHALL cover reset held 20 ns, then en=1, up_dn=1 for 12 steps -> count 0..9, 0, 1; wrap pulses once, after 9->0; tc=1 at count 9.
REQ-036 SHALL cover count=0, up_dn=0, one step -> count=9, wrap=1 for one cycle; MODE_SAT repeat -> count stays 0, wrap=1.
REQ-037 SHALL cover load=1, load_val=7 -> count=7, load_err=0; load_val=12 -> count=9, load_err=1; clear -> count=0, load_err=0.
REQ-038 SHALL cover clear=1, load=1, en=1 in the same cycle -> count=0; load=1, en=1 -> count=load_val, no step.
REQ-039 SHALL cover COUNTER_PRESCALE_EN defined, PRESCALE=3, en=1 for 9 cycles -> exactly 3 increments.
REQ-040 SHALL cover reset asserted mid-prescale at count=5 -> count=0 immediately, no wrap pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter and its prescaler.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Width of a phase register able to hold 0..n-1, never narrower than one bit.
    function automatic int phase_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-rate prescaler: tick is high on one in every PRESCALE enabled cycles.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int PW = phase_width(PRESCALE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE        = PW'(1);
    localparam logic [PW-1:0] ZERO       = {PW{1'b0}};

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Next phase: restart wins; otherwise advance only while enabled.
    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = ZERO;
        end else if (en) begin
            phase_d = (phase_q == LAST_PHASE) ? ZERO : (phase_q + ONE);
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= ZERO;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign tick = en & (phase_q == LAST_PHASE);

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with wrap or saturate mode, load range check and boundary pulse.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int MODE     = MODE_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS out of range for WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_updown_counter: PRESCALE must be at least 1");
    end
    if ((MODE != MODE_WRAP) && (MODE != MODE_SAT)) begin : g_bad_mode
        $error("mod_updown_counter: MODE must be MODE_WRAP or MODE_SAT");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             tick_s;
    logic             step_s;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (clear | load),
        .tick    (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    assign step_s = en & tick_s;
    assign tc     = up_dn ? (count_q == MAX_VAL) : (count_q == ZERO);

    // Next state: clear > load > step; a step at the range end is the boundary event.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (clear) begin
            count_d = ZERO;
            err_d   = 1'b0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                count_d = MAX_VAL;
                err_d   = 1'b1;
            end
        end else if (step_s) begin
            if (tc) begin
                wrap_d = 1'b1;
                if (MODE == MODE_SAT) begin
                    count_d = count_q;
                end else begin
                    count_d = up_dn ? ZERO : MAX_VAL;
                end
            end else begin
                count_d = up_dn ? (count_q + ONE) : (count_q - ONE);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: wrap-mode and saturate-mode counters (WIDTH=4, MODULUS=10) side by side.
module tb_mod_updown_counter;

    localparam int M = 10;
`ifdef COUNTER_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset, clear, load, en, up_dn;
    logic [3:0] load_val;
    logic [3:0] cnt_w, cnt_s;
    logic       tc_w, tc_s, wrap_w, wrap_s, err_w, err_s;

    int total = 0;
    int bad   = 0;

    // Reference model state: index 0 = wrap mode, 1 = saturate mode.
    int m_cnt[2];
    int m_wrap[2];
    int m_err[2];
    int m_ph;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(M), .MODE(counter_pkg::MODE_WRAP), .PRESCALE(PS)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val), .en(en),
        .up_dn(up_dn), .count(cnt_w), .tc(tc_w), .wrap(wrap_w), .load_err(err_w));

    mod_updown_counter #(.WIDTH(4), .MODULUS(M), .MODE(counter_pkg::MODE_SAT), .PRESCALE(PS)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val), .en(en),
        .up_dn(up_dn), .count(cnt_s), .tc(tc_s), .wrap(wrap_s), .load_err(err_s));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input int cw, input int ww, input int ew,
                           input int cs, input int ws, input int es);
        chk({nm, " count_w"}, int'(cnt_w), cw);
        chk({nm, " wrap_w"},  int'(wrap_w), ww);
        chk({nm, " err_w"},   int'(err_w), ew);
        chk({nm, " count_s"}, int'(cnt_s), cs);
        chk({nm, " wrap_s"},  int'(wrap_s), ws);
        chk({nm, " err_s"},   int'(err_s), es);
    endtask

    // One clock edge of the behavioural model, from the counting rules in plain arithmetic.
    task automatic model_edge(input bit c, input bit l, input int lv, input bit e, input bit u);
        bit tick;
        tick = e && (m_ph == PS - 1);
        if (c || l) m_ph = 0;
        else if (e) m_ph = (m_ph + 1) % PS;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            if (c) begin
                m_cnt[k] = 0;
                m_err[k] = 0;
            end else if (l) begin
                if (lv < M) m_cnt[k] = lv;
                else begin
                    m_cnt[k] = M - 1;
                    m_err[k] = 1;
                end
            end else if (tick) begin
                m_wrap[k] = u ? (m_cnt[k] == M - 1) : (m_cnt[k] == 0);
                if (k == 0) m_cnt[k] = u ? (m_cnt[k] + 1) % M : (m_cnt[k] + M - 1) % M;
                else        m_cnt[k] = u ? ((m_cnt[k] + 1 > M - 1) ? M - 1 : m_cnt[k] + 1)
                                         : ((m_cnt[k] - 1 < 0) ? 0 : m_cnt[k] - 1);
            end
        end
    endtask

    typedef struct {
        bit c; bit l; int lv; bit e; bit u;
        int cw; int ww; int ew; int cs; int ws; int es;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //              c     l     lv  e     u     cw ww ew  cs ws es
        tbl[0]  = '{1'b1, 1'b0,  0, 1'b0, 1'b1,  0, 0, 0,  0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0,  9, 1, 0,  0, 1, 0};
        tbl[2]  = '{1'b0, 1'b0,  0, 1'b0, 1'b0,  9, 0, 0,  0, 0, 0};
        tbl[3]  = '{1'b0, 1'b1,  7, 1'b0, 1'b1,  7, 0, 0,  7, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 12, 1'b0, 1'b1,  9, 0, 1,  9, 0, 1};
        tbl[5]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1,  0, 1, 1,  9, 1, 1};
        tbl[6]  = '{1'b1, 1'b0,  0, 1'b0, 1'b1,  0, 0, 0,  0, 0, 0};
        tbl[7]  = '{1'b1, 1'b1,  5, 1'b1, 1'b1,  0, 0, 0,  0, 0, 0};
        tbl[8]  = '{1'b0, 1'b1,  3, 1'b1, 1'b1,  3, 0, 0,  3, 0, 0};
        tbl[9]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0,  2, 0, 0,  2, 0, 0};
        tbl[10] = '{1'b0, 1'b0,  0, 1'b1, 1'b0,  1, 0, 0,  1, 0, 0};
        tbl[11] = '{1'b0, 1'b0,  0, 1'b1, 1'b0,  0, 0, 0,  0, 0, 0};
        tbl[12] = '{1'b0, 1'b0,  0, 1'b1, 1'b0,  9, 1, 0,  0, 1, 0};
        tbl[13] = '{1'b0, 1'b1, 15, 1'b0, 1'b0,  9, 0, 1,  9, 0, 1};
        tbl[14] = '{1'b0, 1'b1,  0, 1'b0, 1'b0,  0, 0, 1,  0, 0, 1};
        tbl[15] = '{1'b0, 1'b0,  0, 1'b1, 1'b0,  9, 1, 1,  0, 1, 1};
        tbl[16] = '{1'b1, 1'b0,  0, 1'b0, 1'b1,  0, 0, 0,  0, 0, 0};

        reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up_dn = 1'b1;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        #18;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all("first edge en=0", 0, 0, 0, 0, 0, 0);

        // Twelve up steps: one wrap after 9->0; saturate holds at 9 and pulses each time.
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("tc before step", int'(tc_w), ((i % M) == M - 1) ? 1 : 0);
            repeat (PS) @(posedge clk);
            #1;
            chk_all("up run", (i + 1) % M, (i == M - 1) ? 1 : 0, 0,
                    (i + 1 > M - 1) ? M - 1 : i + 1, (i >= M - 1) ? 1 : 0, 0);
        end
        en = 1'b0;

        for (int i = 0; i < 17; i++) begin
            clear = tbl[i].c; load = tbl[i].l; load_val = 4'(tbl[i].lv);
            en = tbl[i].e; up_dn = tbl[i].u;
            repeat ((tbl[i].c || tbl[i].l || !tbl[i].e) ? 1 : PS) @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].cw, tbl[i].ww, tbl[i].ew,
                    tbl[i].cs, tbl[i].ws, tbl[i].es);
            chk($sformatf("vec%0d tc_w", i), int'(tc_w),
                tbl[i].u ? ((tbl[i].cw == M - 1) ? 1 : 0) : ((tbl[i].cw == 0) ? 1 : 0));
        end
        clear = 1'b0; load = 1'b0; en = 1'b0;

        // Nine enabled cycles give 9/PS increments, one every PS cycles.
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            chk("prescaled count", int'(cnt_w), (i + 1) / PS);
        end
        en = 1'b0;

        // Reach 5, then reset part-way through the next prescale period.
        load = 1'b1; load_val = 4'd4;
        @(posedge clk); #1;
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (PS) @(posedge clk);
        #1;
        chk("pre-reset count", int'(cnt_w), 5);
        if (PS > 1) begin
            @(posedge clk); #4;
        end else begin
            #3;
        end
        reset = 1'b1;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0, 0);
        en = 1'b0;
        #20;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all("after reset", 0, 0, 0, 0, 0, 0);

        // Randomised traffic against the model.
        m_cnt = '{0, 0}; m_wrap = '{0, 0}; m_err = '{0, 0}; m_ph = 0;
        for (int i = 0; i < 400; i++) begin
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom_range(0, 1));
            #1;
            chk("rand tc_w", int'(tc_w), up_dn ? ((m_cnt[0] == M - 1) ? 1 : 0) : ((m_cnt[0] == 0) ? 1 : 0));
            chk("rand tc_s", int'(tc_s), up_dn ? ((m_cnt[1] == M - 1) ? 1 : 0) : ((m_cnt[1] == 0) ? 1 : 0));
            @(posedge clk);
            model_edge(clear, load, int'(load_val), en, up_dn);
            #1;
            chk_all("rand", m_cnt[0], m_wrap[0], m_err[0], m_cnt[1], m_wrap[1], m_err[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
